bram_pipe: RTL and testbench
============================

# bram_pipe

Parametrised single-clock simple-dual-port block RAM: one write port with byte enables and one read port with a configurable read latency and a response-valid strobe. It replaces the fixed one-cycle BRAM primitive wherever deeper read pipelining is needed for timing, or where defined read-during-write behaviour is required. Optionally, it zero-fills its contents after reset.

## Interface
- width, 32, data bits per word (1..1024)
- n, 5, address bits
- size, 32, number of words (1..2^n)
- latency, 1, read latency in cycles (legal 1..4; other values raise `$error` at elaboration)
- mode, 0, same-address read/write collision: 0 = old data, 1 = new data
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, synchronous, active-low
- READ_EN_WRITE  in  1  read request strobe
- READ_REQ_WRITE  in  n  read address
- READ_RESP_READ  out  width  read data, registered, held between responses
- READ_VALID_READ  out  1  one-cycle strobe marking a new READ_RESP_READ
- WRITE_EN_WRITE  in  1  write strobe
- WRITE_INDEX_WRITE  in  n  write address
- WRITE_DATA_WRITE  in  width  write data
- WRITE_BE_WRITE  in  BE=(width+7)/8  byte enables; lane i covers bits [8i+7:8i], last lane partial when width%8≠0
- BUSY_READ  out  1  high while the block refuses requests (clear in progress)

## Operation
- A write is performed when WRITE_EN_WRITE=1 and BUSY_READ=0. Only lanes whose BE bit is set are updated. An all-zero BE is a no-op.
- A read is accepted when READ_EN_WRITE=1 and BUSY_READ=0. The address and word are captured into a stage-1 register. Stages 2..latency are plain pipeline registers carrying data and valid.
- Collision: a read and a write to the same address in the same cycle. mode 0 returns the pre-write word. mode 1 returns the pre-write word merged with the enabled write lanes.
- An out-of-range address (≥ size) behaves as follows: the write is dropped, and the read returns all zeros with a normal valid strobe.
- Requests while BUSY_READ=1 are ignored. No valid is ever produced for them.
- Back-to-back reads are supported every cycle. There is no backpressure: the consumer must accept each valid.
- Reset (RST_N=0) has these effects:
  - All pipeline valid bits clear.
  - READ_RESP_READ goes to 0 and READ_VALID_READ goes to 0.
  - In-flight reads are discarded.
  - Memory contents are untouched unless BRAM_PIPE_CLEAR_EN is defined.
- BUSY_READ reset value: 0 without the macro, 1 with it.

## Timing
- A read accepted at edge t gives READ_VALID_READ=1 and the corresponding data during the cycle following edge t+latency−1. This is latency cycles after the request cycle.
- A write at edge t is visible to a read accepted at edge t+1 or later, for any mode.
- READ_RESP_READ changes only in cycles where READ_VALID_READ=1, or on reset.
- Reset asserted mid-pipeline: no valid appears on any later cycle for reads issued before reset.

## Configuration
- BRAM_PIPE_CLEAR_EN defined, the zero-fill sequence is as follows:
  - While RST_N=0, an internal clear counter is held at 0 and BUSY_READ=1.
  - After reset release, one word is written with zero per cycle, at addresses 0..size−1.
  - BUSY_READ falls in the cycle after address size−1 is written, so BUSY is high for exactly size cycles after release.
  - Reasserting reset mid-clear restarts from address 0.
- BRAM_PIPE_CLEAR_EN undefined:
  - No counter is built and BUSY_READ is tied 0.
  - Contents power up undefined (X in simulation).

## Test plan
- width=32, latency=3: write 0xDEADBEEF to addr 5 at cycle 0, read addr 5 at cycle 1 -> VALID and data 0xDEADBEEF exactly 3 cycles after the read cycle.
- width=20, BE=3: addr 2 holds 0x12345, write 0xFFFFF with BE=3'b010 -> read returns 0x1FF45.
- Collision at addr 7 (old 0x11, write 0x22, all BE): mode 0 returns 0x11, mode 1 returns 0x22. A read at the next cycle returns 0x22 in both modes.
- latency=4, reads every cycle to addrs 0..7, RST_N pulsed low for 1 cycle after the 3rd request -> no VALID for any of these reads, READ_RESP_READ=0 after reset.
- size=32: write to addr 40 with n=6, then read 40 -> VALID with data 0, and addr 40 mod 32 = 8 unchanged.
- With BRAM_PIPE_CLEAR_EN, size=16: release reset, check BUSY high for 16 cycles and requests ignored during that time; then read all addrs -> every word 0. Reset at clear cycle 8 -> BUSY high 16 more cycles.

Source files
------------

// File: rtl/bram_pipe.sv
// Simple-dual-port block RAM with byte-enable writes, a 1..4 stage read pipeline and a response-valid strobe.
// Define BRAM_PIPE_CLEAR_EN to zero-fill the array after every reset, with BUSY_READ held high while it runs.
module bram_pipe #(
  parameter int width   = 32,
  parameter int n       = 5,
  parameter int size    = 32,
  parameter int latency = 1,
  parameter int mode    = 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    READ_EN_WRITE,
  input  logic [n-1:0]            READ_REQ_WRITE,
  output logic [width-1:0]        READ_RESP_READ,
  output logic                    READ_VALID_READ,
  input  logic                    WRITE_EN_WRITE,
  input  logic [n-1:0]            WRITE_INDEX_WRITE,
  input  logic [width-1:0]        WRITE_DATA_WRITE,
  input  logic [(width+7)/8-1:0]  WRITE_BE_WRITE,
  output logic                    BUSY_READ
);

  localparam int          BE     = (width + 7) / 8;
  localparam int          AW     = (size > 1) ? $clog2(size) : 1;
  localparam int          LAT    = (latency < 1) ? 1 : ((latency > 4) ? 4 : latency);
  localparam logic [31:0] SIZE_U = size;

  if (latency < 1 || latency > 4) begin : g_bad_latency
    $error("bram_pipe: latency must be in 1..4");
  end

  // Replace the enabled byte lanes of old_w with new_w; the top lane may be narrower than 8 bits.
  function automatic logic [width-1:0] merge_lanes(input logic [width-1:0] old_w,
                                                   input logic [width-1:0] new_w,
                                                   input logic [BE-1:0]    be);
    logic [width-1:0] r;
    r = old_w;
    for (int i = 0; i < width; i++) begin
      if (be[i/8]) r[i] = new_w[i];
    end
    return r;
  endfunction

  logic [width-1:0] mem [size];
  logic             busy;
  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_fire;
  logic             rd_acc;
  logic [width-1:0] rd_word;

  assign wr_in_range = (32'(WRITE_INDEX_WRITE) < SIZE_U);
  assign rd_in_range = (32'(READ_REQ_WRITE) < SIZE_U);
  assign wr_fire     = WRITE_EN_WRITE && !busy && wr_in_range;
  assign rd_acc      = READ_EN_WRITE && !busy;

`ifdef BRAM_PIPE_CLEAR_EN
  logic [AW-1:0] clr_cnt;
  logic          clr_busy;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      clr_cnt  <= '0;
      clr_busy <= 1'b1;
    end else if (clr_busy) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == AW'(size - 1)) clr_busy <= 1'b0;
    end
  end

  assign busy = clr_busy;
`else
  assign busy = 1'b0;
`endif

  // User writes and clear writes are mutually exclusive because writes are refused while busy.
  always_ff @(posedge CLK) begin
    if (wr_fire)
      mem[WRITE_INDEX_WRITE[AW-1:0]] <= merge_lanes(mem[WRITE_INDEX_WRITE[AW-1:0]],
                                                    WRITE_DATA_WRITE, WRITE_BE_WRITE);
`ifdef BRAM_PIPE_CLEAR_EN
    if (clr_busy && RST_N) mem[clr_cnt] <= '0;
`endif
  end

  // Out-of-range reads return zero; mode 1 forwards same-cycle write lanes over the stored word.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[READ_REQ_WRITE[AW-1:0]];
      if (mode == 1 && wr_fire && (WRITE_INDEX_WRITE == READ_REQ_WRITE))
        rd_word = merge_lanes(rd_word, WRITE_DATA_WRITE, WRITE_BE_WRITE);
    end
  end

  logic [width-1:0] dat_p [LAT];
  logic [LAT-1:0]   vld_p;

  // Stage 1 captures the array word; later stages are plain shift registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_acc;
      for (int k = 1; k < LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // Each stage loads only behind a valid, so the last stage holds its value between responses.
  always_ff @(posedge CLK) begin
    if (rd_acc) dat_p[0] <= rd_word;
    for (int k = 1; k < LAT; k++) begin
      if (vld_p[k-1]) dat_p[k] <= dat_p[k-1];
    end
    if (!RST_N) dat_p[LAT-1] <= '0;
  end

  assign READ_RESP_READ  = dat_p[LAT-1];
  assign READ_VALID_READ = vld_p[LAT-1];
  assign BUSY_READ       = busy;

endmodule

// File: tb/tb_bram_pipe.sv
// Self-checking bench for bram_pipe: one mode-0 and one mode-1 instance share all inputs and are
// compared every cycle against a queue-based model of the read path.
module tb_bram_pipe;

  localparam int W    = 36;
  localparam int N    = 6;
  localparam int SIZE = 32;
  localparam int LAT  = 3;
  localparam int BE   = (W + 7) / 8;
`ifdef BRAM_PIPE_CLEAR_EN
  localparam bit CLR_ON = 1'b1;
`else
  localparam bit CLR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en;
  logic [N-1:0]  rd_addr;
  logic          wr_en;
  logic [N-1:0]  wr_idx;
  logic [W-1:0]  wr_data;
  logic [BE-1:0] wr_be;
  logic [W-1:0]  resp0, resp1;
  logic          vld0, vld1, busy0, busy1;

  always #5 clk = ~clk;

  bram_pipe #(.width(W), .n(N), .size(SIZE), .latency(LAT), .mode(0)) dut0 (
    .CLK(clk), .RST_N(rst_n),
    .READ_EN_WRITE(rd_en), .READ_REQ_WRITE(rd_addr),
    .READ_RESP_READ(resp0), .READ_VALID_READ(vld0),
    .WRITE_EN_WRITE(wr_en), .WRITE_INDEX_WRITE(wr_idx),
    .WRITE_DATA_WRITE(wr_data), .WRITE_BE_WRITE(wr_be),
    .BUSY_READ(busy0));

  bram_pipe #(.width(W), .n(N), .size(SIZE), .latency(LAT), .mode(1)) dut1 (
    .CLK(clk), .RST_N(rst_n),
    .READ_EN_WRITE(rd_en), .READ_REQ_WRITE(rd_addr),
    .READ_RESP_READ(resp1), .READ_VALID_READ(vld1),
    .WRITE_EN_WRITE(wr_en), .WRITE_INDEX_WRITE(wr_idx),
    .WRITE_DATA_WRITE(wr_data), .WRITE_BE_WRITE(wr_be),
    .BUSY_READ(busy1));

  typedef struct {
    int           due;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
  } rsp_t;

  rsp_t         q[$];
  logic [W-1:0] mem_m [SIZE];
  logic [W-1:0] hold0, hold1;
  logic         exp_vld, exp_busy;
  int           clr_left;
  int           cyc;
  int           checks;
  int           errors;

  // Byte-lane overwrite expressed as a mask over the whole word.
  function automatic logic [W-1:0] lane_mix(input logic [W-1:0] old_w, input logic [W-1:0] new_w,
                                            input logic [BE-1:0] be);
    logic [W-1:0] mask;
    mask = '0;
    for (int b = 0; b < BE; b++) if (be[b]) mask = mask | (W'(8'hFF) << (8 * b));
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic idle_inputs();
    rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_be = '0;
  endtask

  // Advance one edge and update the model from the inputs sampled at that edge.
  task automatic tick();
    rsp_t e;
    bit   wr_ok;
    @(posedge clk);
    cyc++;
    exp_vld = 1'b0;
    if (!rst_n) begin
      q.delete();
      hold0 = '0;
      hold1 = '0;
      clr_left = CLR_ON ? SIZE : 0;
    end else begin
      if (clr_left > 0) begin
        mem_m[SIZE - clr_left] = '0;
        clr_left--;
      end else begin
        wr_ok = wr_en && (int'(wr_idx) < SIZE);
        if (rd_en) begin
          if (int'(rd_addr) < SIZE) begin
            e.d0 = mem_m[rd_addr];
            e.d1 = (wr_ok && wr_idx == rd_addr) ? lane_mix(e.d0, wr_data, wr_be) : e.d0;
          end else begin
            e.d0 = '0;
            e.d1 = '0;
          end
          e.due = cyc + LAT - 1;
          q.push_back(e);
        end
        if (wr_ok) mem_m[wr_idx] = lane_mix(mem_m[wr_idx], wr_data, wr_be);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_vld = 1'b1;
        hold0 = q[0].d0;
        hold1 = q[0].d1;
        void'(q.pop_front());
      end
    end
    exp_busy = (clr_left > 0);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (vld0 !== 1'b0 || vld1 !== 1'b0 || resp0 !== '0 || resp1 !== '0 || busy0 !== exp_busy) begin
        errors++;
        $display("FAIL reset cyc=%0d: vld=%b%b resp=%h/%h busy=%b, required vld=00 resp=0 busy=%b",
                 cyc, vld0, vld1, resp0, resp1, busy0, exp_busy);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < SIZE + 4 && exp_busy; i++) begin
      tick();
      checks++;
      if (busy0 !== exp_busy || busy1 !== exp_busy || vld0 !== 1'b0) begin
        errors++;
        $display("FAIL reset_release cyc=%0d: busy=%b vld=%b, required busy=%b vld=0",
                 cyc, busy0, vld0, exp_busy);
      end
    end
    // Give every word a known value before any read.
    for (int a = 0; a < SIZE; a++) begin
      wr_en = 1'b1; wr_idx = N'(a); wr_data = {$urandom, $urandom}; wr_be = '1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    int rd_cyc;
    wr_en = 1'b1; wr_idx = 6'd5; wr_data = 36'h0DEADBEEF; wr_be = '1;
    tick();
    idle_inputs();
    rd_en = 1'b1; rd_addr = 6'd5;
    tick();
    rd_cyc = cyc;
    idle_inputs();
    repeat (LAT + 1) begin
      tick();
      checks++;
      if (vld0 !== exp_vld || vld1 !== exp_vld || resp0 !== hold0 || resp1 !== hold1) begin
        errors++;
        $display("FAIL write_read cyc=%0d: vld=%b%b resp=%h/%h, required vld=%b resp=%h/%h",
                 cyc, vld0, vld1, resp0, resp1, exp_vld, hold0, hold1);
      end
      if (cyc == rd_cyc + LAT - 1) begin
        checks++;
        if (vld0 !== 1'b1 || resp0 !== 36'h0DEADBEEF) begin
          errors++;
          $display("FAIL write_read_latency cyc=%0d: vld=%b resp=%h, required vld=1 resp=0deadbeef",
                   cyc, vld0, resp0);
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    logic [W-1:0] got;
    bit           seen;
    wr_en = 1'b1; wr_idx = 6'd2; wr_data = 36'h912345678; wr_be = '1;
    tick();
    wr_data = 36'hFFFFFFFFF; wr_be = 5'b10010;
    tick();
    wr_data = 36'h000000000; wr_be = 5'b00000;
    tick();
    idle_inputs();
    rd_en = 1'b1; rd_addr = 6'd2;
    tick();
    idle_inputs();
    seen = 1'b0;
    got = '0;
    repeat (LAT + 1) begin
      tick();
      if (vld0 === 1'b1) begin
        seen = 1'b1;
        got = resp0;
      end
    end
    checks++;
    if (!seen || got !== 36'hF1234FF78) begin
      errors++;
      $display("FAIL byte_enable: seen=%b resp=%h, required seen=1 resp=f1234ff78", seen, got);
    end
  endtask

  task automatic test_collision();
    logic [W-1:0] r0 [2];
    logic [W-1:0] r1 [2];
    int           nv;
    wr_en = 1'b1; wr_idx = 6'd7; wr_data = 36'h11; wr_be = '1;
    tick();
    wr_data = 36'h22; rd_en = 1'b1; rd_addr = 6'd7;
    tick();
    wr_en = 1'b0;
    tick();
    idle_inputs();
    nv = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (vld0 === 1'b1 && nv < 2) begin
        r0[nv] = resp0;
        r1[nv] = resp1;
        nv++;
      end
      tick();
    end
    checks++;
    if (nv != 2 || r0[0] !== 36'h11 || r1[0] !== 36'h22 || r0[1] !== 36'h22 || r1[1] !== 36'h22) begin
      errors++;
      $display("FAIL collision: responses=%0d first=%h/%h second=%h/%h, required 2 first=11/22 second=22/22",
               nv, r0[0], r1[0], r0[1], r1[1]);
    end
  endtask

  task automatic test_out_of_range();
    logic [W-1:0] before8;
    before8 = mem_m[8];
    wr_en = 1'b1; wr_idx = 6'd40; wr_data = {$urandom, $urandom}; wr_be = '1;
    tick();
    idle_inputs();
    rd_en = 1'b1; rd_addr = 6'd40;
    tick();
    rd_addr = 6'd8;
    tick();
    idle_inputs();
    repeat (LAT + 1) begin
      tick();
      checks++;
      if (vld0 !== exp_vld || resp0 !== hold0 || resp1 !== hold1) begin
        errors++;
        $display("FAIL out_of_range cyc=%0d: vld=%b resp=%h/%h, required vld=%b resp=%h/%h",
                 cyc, vld0, resp0, resp1, exp_vld, hold0, hold1);
      end
    end
    checks++;
    if (hold0 !== before8) begin
      errors++;
      $display("FAIL out_of_range_alias: addr8 read=%h, required %h", hold0, before8);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      rd_en   = ($urandom_range(0, 3) != 0);
      rd_addr = N'($urandom_range(0, SIZE + 7));
      wr_en   = ($urandom_range(0, 1) != 0);
      wr_idx  = ($urandom_range(0, 3) == 0) ? rd_addr : N'($urandom_range(0, SIZE + 7));
      wr_data = {$urandom, $urandom};
      wr_be   = BE'($urandom);
      tick();
      checks++;
      if (vld0 !== exp_vld || vld1 !== exp_vld || resp0 !== hold0 || resp1 !== hold1 || busy0 !== exp_busy) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d: vld=%b%b resp=%h/%h busy=%b, required vld=%b resp=%h/%h busy=%b",
                 cyc, vld0, vld1, resp0, resp1, busy0, exp_vld, hold0, hold1, exp_busy);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midpipe();
    int nvld;
    nvld = 0;
    for (int a = 0; a < 3; a++) begin
      rd_en = 1'b1; rd_addr = N'(a);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_inputs();
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      if (vld0 === 1'b1 || vld1 === 1'b1) nvld++;
      checks++;
      if (resp0 !== '0 || resp1 !== '0) begin
        errors++;
        $display("FAIL reset_midpipe_data cyc=%0d: resp=%h/%h, required 0", cyc, resp0, resp1);
      end
    end
    checks++;
    if (nvld != 0) begin
      errors++;
      $display("FAIL reset_midpipe_valid: valid cycles=%0d, required 0", nvld);
    end
    for (int i = 0; i < SIZE + 4 && exp_busy; i++) tick();
  endtask

`ifdef BRAM_PIPE_CLEAR_EN
  task automatic test_clear();
    int busy_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_addr = N'(i); wr_en = 1'b1; wr_idx = N'(i); wr_data = '1; wr_be = '1;
      tick();
      checks++;
      if (busy0 !== 1'b1 || vld0 !== 1'b0) begin
        errors++;
        $display("FAIL clear_busy cyc=%0d: busy=%b vld=%b, required busy=1 vld=0", cyc, busy0, vld0);
      end
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    busy_cnt = 0;
    while (busy_cnt < SIZE + 4) begin
      tick();
      busy_cnt++;
      if (busy0 !== 1'b1) break;
    end
    checks++;
    if (busy_cnt != SIZE || vld0 !== 1'b0) begin
      errors++;
      $display("FAIL clear_length: busy cycles=%0d vld=%b, required %0d vld=0", busy_cnt, vld0, SIZE);
    end
    idle_inputs();
    for (int a = 0; a < SIZE + LAT; a++) begin
      rd_en = (a < SIZE); rd_addr = N'(a);
      tick();
      checks++;
      if (vld0 !== exp_vld || resp0 !== hold0 || (exp_vld && resp0 !== '0)) begin
        errors++;
        $display("FAIL clear_zero cyc=%0d: vld=%b resp=%h, required vld=%b resp=0", cyc, vld0, resp0, exp_vld);
      end
    end
    idle_inputs();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    hold0 = '0;
    hold1 = '0;
    exp_vld = 1'b0;
    exp_busy = CLR_ON;
    clr_left = CLR_ON ? SIZE : 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_byte_enable();
    test_collision();
    test_out_of_range();
    test_back_to_back();
    test_reset_midpipe();
`ifdef BRAM_PIPE_CLEAR_EN
    test_clear();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
